edp_mul_seq: RTL and testbench

Multiply step sequencer for the EBOX data path. On a `start` request it drives the AD, ADA, ADB, AR and MQ control fields of the EDP for one signed 36×36 Booth radix-2 multiply. The operands are the multiplier already in MQ and the multiplicand already in BR. The 72-bit product is left in AR (high word) and MQ (low word). The block sits between the CRAM dispatch and the EDP. While `busy` it overrides the microcode control fields; while idle it drives the no-op field values.

---
 rtl/ebox_pkg.sv | 38 +++
 rtl/booth_dec.sv | 24 ++
 rtl/edp_mul_seq.sv | 120 ++++++++++++
 tb/tb_edp_mul_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebox_pkg.sv
// ebox_pkg: constants and types shared by the EBOX data path sequencers.
//   AD function codes, ADA/ADB/ARL select codes, USR (MQ shift register)
//   function codes, MQM select codes and the multiply sequencer state enum.
package ebox_pkg;

    // AD function codes
    localparam logic [6:0] AD_A   = 7'o37;  // pass A
    localparam logic [6:0] AD_APB = 7'o06;  // A plus B
    localparam logic [6:0] AD_AMB = 7'o51;  // A minus B

    // ADA control: bit 0 enable, bits 1:2 select (00 = AR)
    localparam logic [3:0] ADA_AR = 4'b1000;

    // ADB select codes
    localparam logic [2:0] ADB_NONE = 3'b000;
    localparam logic [2:0] ADB_BR   = 3'b010;

    // AR left/right mux selects
    localparam logic [2:0] ARL_AD   = 3'b000;  // straight AD
    localparam logic [2:0] ARL_SHRT = 3'b111;  // AD arithmetically shifted right one place

    // USR functions for the MQ shift register
    localparam logic [1:0] USR_LOAD = 2'b00;
    localparam logic [1:0] USR_SHL  = 2'b01;
    localparam logic [1:0] USR_SHR  = 2'b10;
    localparam logic [1:0] USR_HOLD = 2'b11;

    // MQM select: AD bit 35 shifted into MQ
    localparam logic [1:0] MQM_ADSH = 2'b00;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CLR  = 2'd1,
        MUL_STEP = 2'd2,
        MUL_DONE = 2'd3
    } mulState_t;

endpackage

// File: rtl/booth_dec.sv
// booth_dec: radix-2 Booth recoder. Maps the pair {mq35, prev} (current
// multiplier LSB and the bit shifted out on the previous step) to the AD
// function code for one iteration. Purely combinational.
//   mq35    - current multiplier LSB
//   prev    - Booth history bit
//   ad_code - AD function: A, A+B or A-B
module booth_dec
    import ebox_pkg::*;
(
    input  logic       mq35,
    input  logic       prev,
    output logic [6:0] ad_code
);

    always_comb begin
        ad_code = AD_A;
        case ({mq35, prev})
            2'b10:   ad_code = AD_AMB;  // start of a run of ones
            2'b01:   ad_code = AD_APB;  // end of a run of ones
            default: ad_code = AD_A;
        endcase
    end

endmodule

// File: rtl/edp_mul_seq.sv
// edp_mul_seq: multiply step sequencer for the EBOX data path.
// On start, drives the EDP control fields through one signed Booth radix-2
// multiply of MQ (multiplier) by BR (multiplicand); the product is left in
// AR (high word) and MQ (low word). While idle, drives no-op field values.
// Ports:
//   eboxClk, reset       - clock and synchronous active-high reset
//   start, abort         - request / abandon an operation
//   MQ35                 - current multiplier LSB from the EDP
//   busy, done           - status; done is a one-cycle pulse
//   CRAM_AD/ADA/ADB      - adder function and operand selects
//   CTL_AR*              - AR mux selects, load and clear strobes
//   CTL_MQ_SEL/MQM_*     - MQ shift function and shift-in select
//   stepCount            - remaining iterations (diagnostic)
module edp_mul_seq
    import ebox_pkg::*;
#(
    parameter int STEPS = 36,
    parameter int CW    = 6
) (
    input  logic          eboxClk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          MQ35,
    output logic          busy,
    output logic          done,
    output logic [0:6]    CRAM_AD,
    output logic [0:3]    CRAM_ADA,
    output logic [0:2]    CRAM_ADB,
    output logic [0:2]    CTL_ARL_SEL,
    output logic [0:2]    CTL_ARR_SEL,
    output logic          CTL_AR00to08load,
    output logic          CTL_AR09to17load,
    output logic          CTL_ARRload,
    output logic          CTL_AR00to11clr,
    output logic          CTL_AR12to17clr,
    output logic          CTL_ARRclr,
    output logic [0:1]    CTL_MQ_SEL,
    output logic [0:1]    CTL_MQM_SEL,
    output logic          CTL_MQM_EN,
    output logic [CW-1:0] stepCount
);

    mulState_t     state_reg;
    mulState_t     state_next;
    logic          prev_reg;
    logic [CW-1:0] count_reg;
    // State flags registered from the next state so the control fields
    // come straight off flops with a single mux level behind them.
    logic          busy_reg;
    logic          done_reg;
    logic          clr_reg;
    logic          step_reg;
    logic [6:0]    booth_ad;

    booth_dec u_booth_dec (
        .mq35    (MQ35),
        .prev    (prev_reg),
        .ad_code (booth_ad)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MUL_IDLE: if (start) state_next = MUL_CLR;
            MUL_CLR:  state_next = MUL_STEP;
            MUL_STEP: if (count_reg == CW'(1)) state_next = MUL_DONE;
            MUL_DONE: state_next = MUL_IDLE;
            default:  state_next = MUL_IDLE;
        endcase
        // abort is meaningless in IDLE, so a coincident start still wins there
        if (abort && (state_reg != MUL_IDLE)) state_next = MUL_IDLE;
    end

    always_ff @(posedge eboxClk) begin
        if (reset) begin
            state_reg <= MUL_IDLE;
            prev_reg  <= 1'b0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            clr_reg   <= 1'b0;
            step_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != MUL_IDLE);
            done_reg  <= (state_next == MUL_DONE);
            clr_reg   <= (state_next == MUL_CLR);
            step_reg  <= (state_next == MUL_STEP);
            if (state_reg == MUL_CLR) begin
                prev_reg  <= 1'b0;
                count_reg <= CW'(STEPS);
            end else if (state_reg == MUL_STEP) begin
                prev_reg  <= MQ35;
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    // MQ35 reaches CRAM_AD combinationally: the Booth pair must reflect the
    // multiplier bit sitting in MQ during the current step.
    assign CRAM_AD          = step_reg ? booth_ad : AD_A;
    assign CRAM_ADA         = ADA_AR;
    assign CRAM_ADB         = step_reg ? ADB_BR : ADB_NONE;
    assign CTL_ARL_SEL      = step_reg ? ARL_SHRT : ARL_AD;
    assign CTL_ARR_SEL      = step_reg ? ARL_SHRT : ARL_AD;
    assign CTL_AR00to08load = step_reg;
    assign CTL_AR09to17load = step_reg;
    assign CTL_ARRload      = step_reg;
    assign CTL_AR00to11clr  = clr_reg;
    assign CTL_AR12to17clr  = clr_reg;
    assign CTL_ARRclr       = clr_reg;
    assign CTL_MQ_SEL       = step_reg ? USR_SHR : USR_HOLD;
    assign CTL_MQM_SEL      = MQM_ADSH;
    assign CTL_MQM_EN       = step_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign stepCount        = count_reg;

endmodule

// File: tb/tb_edp_mul_seq.sv
// tb_edp_mul_seq: bench for edp_mul_seq with a behavioural EDP model
// (AR, MQ, BR and the adder) driven by the sequencer's control outputs.
// Expected products are pushed to a scoreboard when a multiply is issued
// and popped when done is seen.
module tb_edp_mul_seq;

    localparam int STEPS = 36;
    localparam int CW    = 6;

    logic          eboxClk = 1'b0;
    logic          reset   = 1'b1;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic          MQ35;
    logic          busy;
    logic          done;
    logic [0:6]    CRAM_AD;
    logic [0:3]    CRAM_ADA;
    logic [0:2]    CRAM_ADB;
    logic [0:2]    CTL_ARL_SEL;
    logic [0:2]    CTL_ARR_SEL;
    logic          CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload;
    logic          CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr;
    logic [0:1]    CTL_MQ_SEL;
    logic [0:1]    CTL_MQM_SEL;
    logic          CTL_MQM_EN;
    logic [CW-1:0] stepCount;

    int errors = 0;
    int checks = 0;
    int cycle_ctr = 0;
    logic [71:0] exp_q[$];

    edp_mul_seq #(.STEPS(STEPS), .CW(CW)) dut (
        .eboxClk          (eboxClk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .MQ35             (MQ35),
        .busy             (busy),
        .done             (done),
        .CRAM_AD          (CRAM_AD),
        .CRAM_ADA         (CRAM_ADA),
        .CRAM_ADB         (CRAM_ADB),
        .CTL_ARL_SEL      (CTL_ARL_SEL),
        .CTL_ARR_SEL      (CTL_ARR_SEL),
        .CTL_AR00to08load (CTL_AR00to08load),
        .CTL_AR09to17load (CTL_AR09to17load),
        .CTL_ARRload      (CTL_ARRload),
        .CTL_AR00to11clr  (CTL_AR00to11clr),
        .CTL_AR12to17clr  (CTL_AR12to17clr),
        .CTL_ARRclr       (CTL_ARRclr),
        .CTL_MQ_SEL       (CTL_MQ_SEL),
        .CTL_MQM_SEL      (CTL_MQM_SEL),
        .CTL_MQM_EN       (CTL_MQM_EN),
        .stepCount        (stepCount)
    );

    always #5 eboxClk = ~eboxClk;
    always @(posedge eboxClk) cycle_ctr <= cycle_ctr + 1;

    // ---------------- behavioural EDP model ----------------
    logic [35:0] ar = '0, mq = '0, br = '0;
    logic [35:0] ar_next, mq_next;
    logic [36:0] a_ext, b_ext, ad_ext;
    logic [17:0] arl_src, arr_src;
    logic        preset_en = 1'b0;
    logic [35:0] preset_ar = '0, preset_mq = '0, preset_br = '0;

    assign MQ35 = mq[0];

    always_comb begin
        a_ext = '0;
        b_ext = '0;
        if (CRAM_ADA[0] && CRAM_ADA[1:2] == 2'b00) a_ext = {ar[35], ar};
        if (CRAM_ADB == 3'b010) b_ext = {br[35], br};
        case (CRAM_AD)
            7'o06:   ad_ext = a_ext + b_ext;
            7'o51:   ad_ext = a_ext - b_ext;
            default: ad_ext = a_ext;
        endcase
        arl_src = (CTL_ARL_SEL == 3'b111) ? ad_ext[36:19] : ad_ext[35:18];
        arr_src = (CTL_ARR_SEL == 3'b111) ? ad_ext[18:1]  : ad_ext[17:0];
        ar_next = ar;
        if (CTL_AR00to08load) ar_next[35:27] = arl_src[17:9];
        if (CTL_AR09to17load) ar_next[26:18] = arl_src[8:0];
        if (CTL_ARRload)      ar_next[17:0]  = arr_src;
        if (CTL_AR00to11clr)  ar_next[35:24] = '0;
        if (CTL_AR12to17clr)  ar_next[23:18] = '0;
        if (CTL_ARRclr)       ar_next[17:0]  = '0;
        mq_next = mq;
        if (CTL_MQ_SEL == 2'b10)
            mq_next = {(CTL_MQM_EN && CTL_MQM_SEL == 2'b00) ? ad_ext[0] : 1'b0, mq[35:1]};
    end

    always @(posedge eboxClk) begin
        if (preset_en) begin
            ar <= preset_ar;
            mq <= preset_mq;
            br <= preset_br;
        end else begin
            ar <= ar_next;
            mq <= mq_next;
        end
    end

    // ---------------- observation vectors ----------------
    localparam logic [22:0] NOOP_CTL = {7'o37, 4'b1000, 3'b000, 6'b000000, 2'b11, 1'b0};
    localparam logic [23:0] STEP_CTL = {4'b1000, 3'b010, 3'b111, 3'b111, 3'b111, 3'b000,
                                        2'b10, 2'b00, 1'b1};
    logic [22:0] ctl_vec;
    logic [23:0] step_vec;
    logic [2:0]  ctl_clr;
    assign ctl_vec  = {CRAM_AD, CRAM_ADA, CRAM_ADB, CTL_AR00to08load, CTL_AR09to17load,
                       CTL_ARRload, CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr,
                       CTL_MQ_SEL, CTL_MQM_EN};
    assign step_vec = {CRAM_ADA, CRAM_ADB, CTL_ARL_SEL, CTL_ARR_SEL, CTL_AR00to08load,
                       CTL_AR09to17load, CTL_ARRload, CTL_AR00to11clr, CTL_AR12to17clr,
                       CTL_ARRclr, CTL_MQ_SEL, CTL_MQM_SEL, CTL_MQM_EN};
    assign ctl_clr  = {CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr};

    // Preset EDP registers at the next edge; optionally push the expected product.
    task automatic load_ops(input logic [35:0] m, input logic [35:0] b, input bit push);
        logic signed [71:0] pm, pb, p;
        preset_mq = m;
        preset_br = b;
        preset_ar = 36'o525252525252;  // garbage that CLR must wipe
        preset_en = 1'b1;
        pm = {{36{m[35]}}, m};
        pb = {{36{b[35]}}, b};
        p  = pm * pb;
        if (push) exp_q.push_back(p);
    endtask

    // Follow one multiply from its CLR cycle (c=1) to done, checking each cycle.
    task automatic run_op(input string tag, input bit hold_start, output int done_cyc);
        int          c;
        bit          seen;
        logic        bprev;
        logic [6:0]  exp_ad;
        logic [71:0] exp_p;
        c = 0; seen = 0; bprev = 1'b0; done_cyc = 0;
        while (!seen && c < STEPS + 8) begin
            @(negedge eboxClk);
            c++;
            if (c == 1) begin
                preset_en = 1'b0;
                abort     = 1'b0;
                if (!hold_start) start = 1'b0;
                checks++;
                if (busy !== 1'b1 || ctl_clr !== 3'b111 || CTL_MQ_SEL !== 2'b11) begin
                    errors++;
                    $display("FAIL %s clr_cycle: busy=%b clr=%b mq_sel=%b, want busy=1 clr=111 mq_sel=11",
                             tag, busy, ctl_clr, CTL_MQ_SEL);
                end
            end else if (c <= STEPS + 1) begin
                exp_ad = (mq[0] == bprev) ? 7'o37 : (mq[0] ? 7'o51 : 7'o06);
                checks++;
                if (CRAM_AD !== exp_ad) begin
                    errors++;
                    $display("FAIL %s step_ad c=%0d: got %o, want %o", tag, c, CRAM_AD, exp_ad);
                end
                checks++;
                if (stepCount !== CW'(STEPS + 2 - c)) begin
                    errors++;
                    $display("FAIL %s step_count c=%0d: got %0d, want %0d", tag, c, stepCount,
                             STEPS + 2 - c);
                end
                checks++;
                if (step_vec !== STEP_CTL) begin
                    errors++;
                    $display("FAIL %s step_ctl c=%0d: got %h, want %h", tag, c, step_vec, STEP_CTL);
                end
                bprev = mq[0];
            end
            if (done === 1'b1) begin
                seen = 1;
                done_cyc = cycle_ctr;
                checks++;
                if (c != STEPS + 2) begin
                    errors++;
                    $display("FAIL %s done_latency: got cycle %0d, want %0d", tag, c, STEPS + 2);
                end
                checks++;
                if (ctl_vec !== NOOP_CTL || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s done_ctl: got ctl=%h busy=%b, want ctl=%h busy=1",
                             tag, ctl_vec, busy, NOOP_CTL);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s scoreboard: got done, want no done (queue empty)", tag);
                end else begin
                    exp_p = exp_q.pop_front();
                    if ({ar, mq} !== exp_p) begin
                        errors++;
                        $display("FAIL %s product: got AR=%o MQ=%o, want AR=%o MQ=%o",
                                 tag, ar, mq, exp_p[71:36], exp_p[35:0]);
                    end
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no done in %0d cycles, want done at %0d", tag, c, STEPS + 2);
        end
        $display("op %s: AR=%o MQ=%o done_cycle=%0d", tag, ar, mq, c);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;  // start must be ignored under reset
        repeat (3) @(negedge eboxClk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, want 0", done); end
        checks++;
        if (stepCount !== '0) begin errors++; $display("FAIL reset_count: got %0d, want 0", stepCount); end
        checks++;
        if (ctl_vec !== NOOP_CTL) begin
            errors++;
            $display("FAIL reset_ctl: got %h, want %h", ctl_vec, NOOP_CTL);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge eboxClk);
    endtask

    task automatic test_products;
        logic [35:0] m_tab[5];
        logic [35:0] b_tab[5];
        int d;
        m_tab[0] = 36'd3;             b_tab[0] = 36'd5;
        m_tab[1] = 36'o777777777777;  b_tab[1] = 36'd7;
        m_tab[2] = 36'o400000000000;  b_tab[2] = 36'o400000000000;
        m_tab[3] = {4'($urandom), 32'($urandom)};  b_tab[3] = {4'($urandom), 32'($urandom)};
        m_tab[4] = {4'($urandom), 32'($urandom)};  b_tab[4] = {4'($urandom), 32'($urandom)};
        for (int i = 0; i < 5; i++) begin
            load_ops(m_tab[i], b_tab[i], 1'b1);
            start = 1'b1;
            run_op($sformatf("prod%0d", i), 1'b0, d);
            @(negedge eboxClk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL prod%0d idle_after: got busy=%b done=%b, want 0 0", i, busy, done);
            end
        end
    endtask

    task automatic test_abort;
        bit seen;
        int d;
        load_ops(36'd11, 36'd13, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 11; c++) begin  // c=11 is the 10th STEP cycle
            @(negedge eboxClk);
            if (c == 1) begin start = 1'b0; preset_en = 1'b0; end
        end
        abort = 1'b1;
        @(negedge eboxClk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ctl_vec !== NOOP_CTL) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b done=%b ctl=%h, want 0 0 %h",
                     busy, done, ctl_vec, NOOP_CTL);
        end
        seen = 0;
        repeat (45) begin
            @(negedge eboxClk);
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL abort_no_done: got done pulse, want none"); end
        // start and abort together in IDLE: start wins
        load_ops(36'd3, 36'd5, 1'b1);
        start = 1'b1;
        abort = 1'b1;
        run_op("after_abort", 1'b0, d);
        @(negedge eboxClk);
    endtask

    task automatic test_reset_mid;
        int d;
        load_ops(36'd21, 36'd17, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge eboxClk);
            if (c == 1) preset_en = 1'b0;
        end
        reset = 1'b1;
        @(negedge eboxClk);  // first IDLE sample
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stepCount !== '0 || ctl_vec !== NOOP_CTL) begin
            errors++;
            $display("FAIL reset_mid_idle: got busy=%b done=%b count=%0d ctl=%h, want 0 0 0 %h",
                     busy, done, stepCount, ctl_vec, NOOP_CTL);
        end
        reset = 1'b0;
        load_ops(36'd3, 36'd5, 1'b1);
        run_op("after_reset", 1'b1, d);
        start = 1'b0;
        @(negedge eboxClk);
    endtask

    task automatic test_back_to_back;
        logic [35:0] m_tab[3];
        logic [35:0] b_tab[3];
        int d_prev, d_cur;
        m_tab[0] = 36'd3;              b_tab[0] = 36'd5;
        m_tab[1] = 36'o777777777771;   b_tab[1] = 36'o123456701234;
        m_tab[2] = 36'o377777777777;   b_tab[2] = 36'o400000000000;
        load_ops(m_tab[0], b_tab[0], 1'b1);
        start = 1'b1;
        run_op("b2b0", 1'b1, d_prev);
        for (int k = 1; k < 3; k++) begin
            load_ops(m_tab[k], b_tab[k], 1'b1);  // lands at the DONE->IDLE edge
            @(negedge eboxClk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL b2b%0d idle_gap: got busy=%b done=%b, want 0 0", k, busy, done);
            end
            run_op($sformatf("b2b%0d", k), 1'b1, d_cur);
            checks++;
            if (d_cur - d_prev != STEPS + 3) begin
                errors++;
                $display("FAIL b2b%0d interval: got %0d, want %0d", k, d_cur - d_prev, STEPS + 3);
            end
            d_prev = d_cur;
        end
        start = 1'b0;
        @(negedge eboxClk);
    endtask

    initial begin
        test_reset();
        test_products();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
